regfile_operand_sequencer: RTL and testbench
============================================

Name: regfile_operand_sequencer

Overview:
- Front-end controller for the single-read-port, single-write-port register file. It serialises the two source-operand reads of an instruction (rs1 then rs2) over the one registered read port.
- Passes writeback traffic to the write port, hardwires register 0 to zero, and forwards or snoops writebacks so the returned operands are never stale.
- Sits between decode (request/response handshakes) and the register file.

Parameters:
- N, 64, register width in bits
- M, 32, number of registers; AW = $clog2(M) is a derived localparam
- ZERO_REG, 1, when 1, reads of address 0 return 0 and writes to address 0 are suppressed

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- req_valid  in  1  operand request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_rs1  in  AW  first source address
- req_rs2  in  AW  second source address
- rsp_valid  out  1  operands valid
- rsp_ready  in  1  consumer accepts operands
- rsp_op1  out  N  rs1 value
- rsp_op2  out  N  rs2 value
- wb_valid  in  1  writeback valid; always accepted, no backpressure
- wb_addr  in  AW  writeback destination
- wb_data  in  N  writeback data
- rf_raddr  out  AW  to register file ReadAddr
- rf_ren  out  1  to register file REn
- rf_rdata  in  N  from register file Vout (registered, 1-cycle read latency)
- rf_waddr  out  AW  to WriteAddr
- rf_wdata  out  N  to Vin
- rf_wen  out  1  to WEn

Behaviour:
- Interface: one clock (Clk). Reset (Rst) is synchronous and active-high.
- FSM states: IDLE, RD1, RD2, CAP, RESP.
- IDLE:
  - req_ready=1.
  - On accept, latch rs1_q/rs2_q, clear both forward flags, then go to RD1.
- RD1:
  - rf_ren=1, rf_raddr=rs1_q.
  - Go to RD2.
- RD2:
  - rf_ren=1, rf_raddr=rs2_q.
  - op1 <= rf_rdata unless fwd1 is set.
  - Go to CAP.
- CAP:
  - rf_ren=0, rf_raddr=rs2_q.
  - op2 <= rf_rdata unless fwd2 is set.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_op1/rsp_op2 are held stable until handshake.
  - On rsp_ready: if req_valid, accept a new request in the same cycle (req_ready = rsp_ready) and go to RD1; otherwise go to IDLE.
- Latency and throughput:
  - Request accepted at edge k; rsp_valid is high in the cycle after edge k+3.
  - Throughput is one request per 4 cycles with rsp_ready held high.
- Write path:
  - rf_waddr=wb_addr, rf_wdata=wb_data (combinational).
  - rf_wen = wb_valid & !(ZERO_REG & wb_addr==0).
- Snoop/forward:
  - Applies in states RD1, RD2, CAP, and RESP before the handshake.
  - An effective write (rf_wen=1) with wb_addr==rs1_q sets op1 <= wb_data and fwd1 <= 1. The same rule applies to rs2_q with op2/fwd2.
  - The latest write wins.
  - Covers a same-edge write that the register file read would miss, and writes after capture.
- Capture precedence: a forward write in the capture cycle (RD2 for op1, CAP for op2) overrides rf_rdata.
- rs1==rs2 is legal; both operands are snooped independently.
- Zero register: when ZERO_REG=1 and address==0, the operand is forced to 0 at capture and never snooped. The read is still issued.
- req_ready and rf_ren are combinational from state and rsp_ready only. They never depend on req_valid.
- Reset, including mid-operation:
  - State goes to IDLE; rsp_valid=0; rsp_op1=rsp_op2=0; fwd flags=0; rs1_q=rs2_q=0.
  - rf_ren=0 while Rst=1; req_ready=0 while Rst=1.
  - The write path is not gated; the register file's own reset has priority.
- rsp_op* are registered. Values of rf_rdata outside the capture cycles are ignored, including high-Z.

Decomposition:
- Shared package rv_rf_pkg: FSM state encoding localparams (IDLE=0..RESP=4, 3-bit), ZERO_REG default, RF_LAT=1 read-latency constant.
- One natural sub-module, regfile_operand_slot, instantiated twice (op1, op2). It holds the address register, data register and fwd flag, with capture-enable, snoop compare and zero-force logic.

Test Plan:
- Preload x5=0xA5, x7=0x3C. Request rs1=5, rs2=7 at edge 0 with rsp_ready=1 -> rsp_valid in the cycle after edge 3 with op1=0xA5, op2=0x3C; req_ready low from edge 0 until RESP.
- Request rs1=0, rs2=0 after a write of 0xFF to x0 -> rf_wen=0, op1=op2=0.
- Write x5=0x11 with wb_valid asserted in the RD1 cycle of a request rs1=5 -> op1=0x11, not the old 0xA5.
- Hold rsp_ready=0 in RESP and write x7=0x22 -> op2 updates to 0x22 on the next edge, op1 unchanged, rsp_valid stays 1.
- Two back-to-back requests (5,7) then (7,5) with rsp_ready=1 -> second accepted in the first RESP cycle, responses 4 cycles apart, correct values.
- Assert Rst in RD2 -> next cycle IDLE, rsp_valid=0, rsp_op1=rsp_op2=0, rf_ren=0; a fresh request then completes normally.

Source files
------------

// File: rtl/rv_rf_pkg.sv
// Shared definitions for the register-file operand sequencer.
//   - FSM state encoding (3-bit) and the typed state enum built on it
//   - ZERO_REG_DEFAULT: default for hardwiring register 0 to zero
//   - RF_LAT: read latency of the register file (registered read port)
package rv_rf_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD1  = 3'd1;
    localparam logic [2:0] RD2  = 3'd2;
    localparam logic [2:0] CAP  = 3'd3;
    localparam logic [2:0] RESP = 3'd4;

    typedef enum logic [2:0] {
        StIdle = IDLE,
        StRd1  = RD1,
        StRd2  = RD2,
        StCap  = CAP,
        StResp = RESP
    } seq_state_e;

    localparam bit          ZERO_REG_DEFAULT = 1'b1;
    localparam int unsigned RF_LAT           = 1;

endpackage

// File: rtl/regfile_operand_sequencer_if.sv
// Bus bundle between decode, the operand sequencer and the register file.
//   slave  : sequencer view (takes requests/writebacks, drives RF port)
//   master : environment view (decode + writeback + register file)
// Signals: req_* request handshake, rsp_* operand response handshake,
//          wb_* writeback, rf_* register file read/write port.
interface regfile_operand_sequencer_if #(
    parameter int unsigned N  = 64,
    parameter int unsigned AW = 5
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_rs1;
    logic [AW-1:0] req_rs2;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_op1;
    logic [N-1:0]  rsp_op2;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [N-1:0]  wb_data;
    logic [AW-1:0] rf_raddr;
    logic          rf_ren;
    logic [N-1:0]  rf_rdata;
    logic [AW-1:0] rf_waddr;
    logic [N-1:0]  rf_wdata;
    logic          rf_wen;

    modport slave (
        input  req_valid, req_rs1, req_rs2, rsp_ready, wb_valid, wb_addr, wb_data, rf_rdata,
        output req_ready, rsp_valid, rsp_op1, rsp_op2, rf_raddr, rf_ren, rf_waddr, rf_wdata,
               rf_wen
    );

    modport master (
        output req_valid, req_rs1, req_rs2, rsp_ready, wb_valid, wb_addr, wb_data, rf_rdata,
        input  req_ready, rsp_valid, rsp_op1, rsp_op2, rf_raddr, rf_ren, rf_waddr, rf_wdata,
               rf_wen
    );

endinterface

// File: rtl/regfile_operand_slot.sv
// One operand slot: source address, operand data and forward flag.
//   Clk, Rst      : clock, synchronous active-high reset
//   i_load        : latch a new source address, clear the forward flag
//   i_addr        : new source address
//   i_capture     : capture cycle for the register-file read data
//   i_snoop_en    : writebacks may update the operand this cycle
//   i_rdata       : register-file read data
//   i_wen/i_waddr/i_wdata : effective writeback
//   o_addr/o_data : held address and operand value
module regfile_operand_slot
    import rv_rf_pkg::*;
#(
    parameter int unsigned N        = 64,
    parameter int unsigned AW       = 5,
    parameter bit          ZERO_REG = ZERO_REG_DEFAULT
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          i_load,
    input  logic [AW-1:0] i_addr,
    input  logic          i_capture,
    input  logic          i_snoop_en,
    input  logic [N-1:0]  i_rdata,
    input  logic          i_wen,
    input  logic [AW-1:0] i_waddr,
    input  logic [N-1:0]  i_wdata,
    output logic [AW-1:0] o_addr,
    output logic [N-1:0]  o_data
);

    logic [AW-1:0] r_addr;
    logic [N-1:0]  r_data;
    logic          r_fwd;
    logic          w_zero;
    logic          w_hit;

    assign w_zero = ZERO_REG && (r_addr == '0);
    // A zero-register operand is never snooped so it stays forced to 0.
    assign w_hit  = i_snoop_en && i_wen && (i_waddr == r_addr) && !w_zero;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_addr <= '0;
            r_data <= '0;
            r_fwd  <= 1'b0;
        end else if (i_load) begin
            r_addr <= i_addr;
            r_fwd  <= 1'b0;
        end else if (w_hit) begin
            // Forwarded write beats the read data, even in the capture cycle.
            r_data <= i_wdata;
            r_fwd  <= 1'b1;
        end else if (i_capture && !r_fwd) begin
            r_data <= w_zero ? '0 : i_rdata;
        end
    end

    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule

// File: rtl/regfile_operand_sequencer.sv
// Operand sequencer: serialises rs1/rs2 reads over the single registered
// read port, passes writebacks to the write port and snoops them so the
// returned operands are never stale.
//   Clk : clock       Rst : synchronous active-high reset
//   bus : request/response handshake, writeback and register-file port
module regfile_operand_sequencer
    import rv_rf_pkg::*;
#(
    parameter int unsigned N        = 64,
    parameter int unsigned M        = 32,
    parameter bit          ZERO_REG = ZERO_REG_DEFAULT
) (
    input  logic                        Clk,
    input  logic                        Rst,
    regfile_operand_sequencer_if.slave  bus
);

    localparam int unsigned AW = $clog2(M);

    seq_state_e    r_state;
    seq_state_e    w_state_next;
    logic          w_req_ready;
    logic          w_rf_ren;
    logic          w_snoop_en;
    logic          w_accept;
    logic          w_wen;
    logic [AW-1:0] w_rs1;
    logic [AW-1:0] w_rs2;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // req_ready/rf_ren depend only on state and rsp_ready, never req_valid.
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_rf_ren     = 1'b0;
        w_snoop_en   = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) w_state_next = StRd1;
            end
            StRd1: begin
                w_rf_ren     = 1'b1;
                w_snoop_en   = 1'b1;
                w_state_next = StRd2;
            end
            StRd2: begin
                w_rf_ren     = 1'b1;
                w_snoop_en   = 1'b1;
                w_state_next = StCap;
            end
            StCap: begin
                w_snoop_en   = 1'b1;
                w_state_next = StResp;
            end
            StResp: begin
                w_req_ready = bus.rsp_ready;
                // In the handshake cycle the held operands are consumed.
                w_snoop_en  = !bus.rsp_ready;
                if (bus.rsp_ready) w_state_next = bus.req_valid ? StRd1 : StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign bus.req_ready = w_req_ready && !Rst;
    assign bus.rf_ren    = w_rf_ren && !Rst;
    assign w_accept      = bus.req_valid && bus.req_ready;

    assign bus.rf_raddr  = (r_state == StRd1) ? w_rs1 : w_rs2;
    assign bus.rsp_valid = (r_state == StResp);

    // Write path is not gated by reset; the register file resolves that itself.
    assign w_wen        = bus.wb_valid && !(ZERO_REG && (bus.wb_addr == '0));
    assign bus.rf_wen   = w_wen;
    assign bus.rf_waddr = bus.wb_addr;
    assign bus.rf_wdata = bus.wb_data;

    regfile_operand_slot #(
        .N        (N),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_slot_op1 (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_load     (w_accept),
        .i_addr     (bus.req_rs1),
        .i_capture  (r_state == StRd2),
        .i_snoop_en (w_snoop_en),
        .i_rdata    (bus.rf_rdata),
        .i_wen      (w_wen),
        .i_waddr    (bus.wb_addr),
        .i_wdata    (bus.wb_data),
        .o_addr     (w_rs1),
        .o_data     (bus.rsp_op1)
    );

    regfile_operand_slot #(
        .N        (N),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_slot_op2 (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_load     (w_accept),
        .i_addr     (bus.req_rs2),
        .i_capture  (r_state == StCap),
        .i_snoop_en (w_snoop_en),
        .i_rdata    (bus.rf_rdata),
        .i_wen      (w_wen),
        .i_waddr    (bus.wb_addr),
        .i_wdata    (bus.wb_data),
        .o_addr     (w_rs2),
        .o_data     (bus.rsp_op2)
    );

endmodule

// File: tb/tb_regfile_operand_sequencer.sv
// Directed bench for regfile_operand_sequencer with a behavioural
// register file (registered read, read-before-write on the same edge).
module tb_regfile_operand_sequencer;

    logic clk;
    logic rst;
    logic mem_init;
    int   nvec;
    int   nmis;

    logic [63:0] mem [32];
    logic [63:0] rdata_q;

    regfile_operand_sequencer_if #(.N(64), .AW(5)) bus ();

    regfile_operand_sequencer #(
        .N        (64),
        .M        (32),
        .ZERO_REG (1'b1)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model; x0 holds a non-zero pattern so zero-forcing is visible.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 64'hBAD0_0000_0000_0000 | 64'(i);
        end else if (bus.rf_wen) begin
            mem[bus.rf_waddr] <= bus.rf_wdata;
        end
        if (bus.rf_ren) rdata_q <= mem[bus.rf_raddr];
    end
    assign bus.rf_rdata = rdata_q;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nvec          = 0;
        nmis          = 0;
        rst           = 1'b1;
        mem_init      = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.rsp_ready = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;

        tick();
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rf_ren", 64'(bus.rf_ren), 64'd0);
        tick();
        mem_init = 1'b0;
        rst      = 1'b0;
        #1;
        chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("idle_op1", bus.rsp_op1, 64'd0);
        chk("idle_op2", bus.rsp_op2, 64'd0);
        chk("idle_req_ready", 64'(bus.req_ready), 64'd1);

        // Preload x5 = A5, x7 = 3C; write to x0 is suppressed.
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd5;
        bus.wb_data  = 64'hA5;
        #1;
        chk("wen_x5", 64'(bus.rf_wen), 64'd1);
        chk("wdata_x5", bus.rf_wdata, 64'hA5);
        tick();
        bus.wb_addr = 5'd7;
        bus.wb_data = 64'h3C;
        tick();
        bus.wb_addr = 5'd0;
        bus.wb_data = 64'hFF;
        #1;
        chk("wen_x0", 64'(bus.rf_wen), 64'd0);
        tick();
        bus.wb_valid = 1'b0;

        // Basic request (5,7), latency and req_ready timing.
        bus.req_valid = 1'b1;
        bus.req_rs1   = 5'd5;
        bus.req_rs2   = 5'd7;
        tick();
        bus.req_valid = 1'b0;
        #1;
        chk("t1_rd1_ready", 64'(bus.req_ready), 64'd0);
        chk("t1_rd1_ren", 64'(bus.rf_ren), 64'd1);
        chk("t1_rd1_raddr", 64'(bus.rf_raddr), 64'd5);
        tick();
        chk("t1_rd2_ready", 64'(bus.req_ready), 64'd0);
        chk("t1_rd2_raddr", 64'(bus.rf_raddr), 64'd7);
        tick();
        chk("t1_cap_ren", 64'(bus.rf_ren), 64'd0);
        chk("t1_cap_valid", 64'(bus.rsp_valid), 64'd0);
        tick();
        chk("t1_resp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t1_op1", bus.rsp_op1, 64'hA5);
        chk("t1_op2", bus.rsp_op2, 64'h3C);
        chk("t1_resp_ready", 64'(bus.req_ready), 64'd1);
        tick();
        chk("t1_back_idle", 64'(bus.rsp_valid), 64'd0);

        // Zero register: x0 reads as 0 even with an x0 write in flight.
        bus.req_valid = 1'b1;
        bus.req_rs1   = 5'd0;
        bus.req_rs2   = 5'd0;
        tick();
        bus.req_valid = 1'b0;
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 5'd0;
        bus.wb_data   = 64'hFF;
        #1;
        chk("t2_wen_x0", 64'(bus.rf_wen), 64'd0);
        tick();
        bus.wb_valid = 1'b0;
        tick();
        tick();
        chk("t2_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t2_op1", bus.rsp_op1, 64'd0);
        chk("t2_op2", bus.rsp_op2, 64'd0);
        tick();

        // Same-edge write in RD1 is forwarded; then snoop while stalled in RESP.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_rs1   = 5'd5;
        bus.req_rs2   = 5'd7;
        tick();
        bus.req_valid = 1'b0;
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 5'd5;
        bus.wb_data   = 64'h11;
        tick();
        bus.wb_valid = 1'b0;
        tick();
        tick();
        chk("t3_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t3_op1_fwd", bus.rsp_op1, 64'h11);
        chk("t3_op2", bus.rsp_op2, 64'h3C);
        chk("t3_stall_ready", 64'(bus.req_ready), 64'd0);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd7;
        bus.wb_data  = 64'h22;
        tick();
        bus.wb_valid = 1'b0;
        chk("t4_valid_held", 64'(bus.rsp_valid), 64'd1);
        chk("t4_op2_snoop", bus.rsp_op2, 64'h22);
        chk("t4_op1_held", bus.rsp_op1, 64'h11);
        bus.rsp_ready = 1'b1;
        #1;
        chk("t4_ready_hs", 64'(bus.req_ready), 64'd1);
        tick();
        chk("t4_idle", 64'(bus.rsp_valid), 64'd0);

        // Back-to-back (5,7) then (7,5); x5 = 11, x7 = 22 now.
        bus.req_valid = 1'b1;
        bus.req_rs1   = 5'd5;
        bus.req_rs2   = 5'd7;
        tick();
        bus.req_rs1 = 5'd7;
        bus.req_rs2 = 5'd5;
        #1;
        chk("t5_rd1_ready", 64'(bus.req_ready), 64'd0);
        tick();
        tick();
        tick();
        chk("t5a_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t5a_op1", bus.rsp_op1, 64'h11);
        chk("t5a_op2", bus.rsp_op2, 64'h22);
        chk("t5a_ready", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 1'b0;
        chk("t5b_rd1_valid", 64'(bus.rsp_valid), 64'd0);
        chk("t5b_rd1_raddr", 64'(bus.rf_raddr), 64'd7);
        tick();
        tick();
        tick();
        chk("t5b_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t5b_op1", bus.rsp_op1, 64'h22);
        chk("t5b_op2", bus.rsp_op2, 64'h11);
        tick();

        // Reset asserted in RD2.
        bus.req_valid = 1'b1;
        bus.req_rs1   = 5'd5;
        bus.req_rs2   = 5'd7;
        tick();
        bus.req_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_ren", 64'(bus.rf_ren), 64'd0);
        chk("t6_rst_ready", 64'(bus.req_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_valid", 64'(bus.rsp_valid), 64'd0);
        chk("t6_op1", bus.rsp_op1, 64'd0);
        chk("t6_op2", bus.rsp_op2, 64'd0);
        chk("t6_ren", 64'(bus.rf_ren), 64'd0);
        chk("t6_ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_rs1   = 5'd7;
        bus.req_rs2   = 5'd5;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_new_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t6_new_op1", bus.rsp_op1, 64'h22);
        chk("t6_new_op2", bus.rsp_op2, 64'h11);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
